out_wb_ctrl: RTL and testbench

Output write-back controller for a convolution layer. It drains result words from the output FIFO into output BRAM. It sequences the `out_addr_gen` address generator through `addr_rst` and `addr_inc`, and pairs each popped word with the address that was current when it was popped. It sits between the PE output FIFO and the output BRAM port, and it signals layer completion to the top-level layer scheduler.

---
 rtl/out_wb_ctrl.sv | 170 +++++++++++++++++
 tb/tb_out_wb_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/out_wb_ctrl.sv
// Output write-back controller: drains the PE output FIFO into output BRAM,
// pairing each popped word with the address-generator output current at the pop.
module out_wb_ctrl #(
    parameter int unsigned BRAM_ADDR_BIT  = 32,
    parameter int unsigned NO_ENTRY_BIT   = 16,
    parameter int unsigned NO_CHANNEL_BIT = 11,
    parameter int unsigned NO_PASS_BIT    = 8,
    parameter int unsigned DATA_BIT       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NO_ENTRY_BIT-1:0]   no_entry,
    input  logic [NO_CHANNEL_BIT-1:0] no_channel,
    input  logic [NO_PASS_BIT-1:0]    no_pass,
    input  logic                      ff_empty,
    input  logic [DATA_BIT-1:0]       ff_dout,
    output logic                      ff_ren,
    output logic                      addr_rst,
    output logic                      addr_inc,
    input  logic [BRAM_ADDR_BIT-1:0]  gen_addr,
    output logic                      bram_en,
    output logic                      bram_we,
    output logic [BRAM_ADDR_BIT-1:0]  bram_addr,
    output logic [DATA_BIT-1:0]       bram_din,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NO_ENTRY_BIT-1:0]   r_no_entry;
    logic [NO_CHANNEL_BIT-1:0] r_no_channel;
    logic [NO_PASS_BIT-1:0]    r_no_pass;
    logic [NO_ENTRY_BIT-1:0]   r_ent;
    logic [NO_CHANNEL_BIT-1:0] r_ch;
    logic [NO_PASS_BIT-1:0]    r_pass;

    logic                      r_v1;
    logic [BRAM_ADDR_BIT-1:0]  r_addr_q;
    logic                      r_bram_we;
    logic [BRAM_ADDR_BIT-1:0]  r_bram_addr;
    logic [DATA_BIT-1:0]       r_bram_din;
    logic                      r_addr_rst;
    logic                      r_busy;
    logic                      r_done;

    logic w_ren;
    logic w_ent_wrap;
    logic w_ch_wrap;
    logic w_last;
    logic w_zero;

    assign w_ent_wrap = (r_ent == r_no_entry - NO_ENTRY_BIT'(1));
    assign w_ch_wrap  = (r_ch == r_no_channel - NO_CHANNEL_BIT'(1));
    assign w_last     = w_ent_wrap && w_ch_wrap && (r_pass == r_no_pass - NO_PASS_BIT'(1));
    assign w_zero     = (r_no_entry == '0) || (r_no_channel == '0) || (r_no_pass == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLEAR;
            S_CLEAR: w_next = w_zero ? S_DONE : S_RUN;
            S_RUN:   if (w_ren && w_last) w_next = S_DRAIN;
            S_DRAIN: if (!r_v1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FIFO pop is combinational so a word can be taken every cycle
    always_comb begin
        w_ren = 1'b0;
        if (r_state == S_RUN && !ff_empty) w_ren = 1'b1;
    end

    // Config latch and nested entry/channel/pass pop counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_no_entry   <= '0;
            r_no_channel <= '0;
            r_no_pass    <= '0;
            r_ent        <= '0;
            r_ch         <= '0;
            r_pass       <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_no_entry   <= no_entry;
                r_no_channel <= no_channel;
                r_no_pass    <= no_pass;
            end
            if (r_state == S_CLEAR) begin
                r_ent  <= '0;
                r_ch   <= '0;
                r_pass <= '0;
            end else if (w_ren) begin
                if (!w_ent_wrap) begin
                    r_ent <= r_ent + NO_ENTRY_BIT'(1);
                end else begin
                    r_ent <= '0;
                    if (!w_ch_wrap) begin
                        r_ch <= r_ch + NO_CHANNEL_BIT'(1);
                    end else begin
                        r_ch   <= '0;
                        r_pass <= r_pass + NO_PASS_BIT'(1);
                    end
                end
            end
        end
    end

    // Two-stage write pipeline: capture address at pop, write when data arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_addr_q    <= '0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else begin
            r_v1      <= w_ren;
            r_bram_we <= r_v1;
            if (w_ren) r_addr_q <= gen_addr;
            if (r_v1) begin
                r_bram_addr <= r_addr_q;
                r_bram_din  <= ff_dout;
            end
        end
    end

    // Status strobes registered from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_rst <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_addr_rst <= (w_next == S_CLEAR);
            r_busy     <= (w_next == S_CLEAR) || (w_next == S_RUN) || (w_next == S_DRAIN);
            r_done     <= (w_next == S_DONE);
        end
    end

    assign ff_ren    = w_ren;
    assign addr_inc  = w_ren;
    assign addr_rst  = r_addr_rst;
    assign bram_en   = r_bram_we;
    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_din  = r_bram_din;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_out_wb_ctrl.sv
// Bench for out_wb_ctrl with a FIFO model, a behavioural address generator
// and an expected write list built from the layer loop nest.
module tb_out_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] no_entry;
    logic [10:0] no_channel;
    logic [7:0]  no_pass;
    logic        ff_empty;
    logic [31:0] ff_dout;
    logic        ff_ren;
    logic        addr_rst;
    logic        addr_inc;
    logic [31:0] gen_addr;
    logic        bram_en;
    logic        bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    out_wb_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .no_entry(no_entry), .no_channel(no_channel), .no_pass(no_pass),
        .ff_empty(ff_empty), .ff_dout(ff_dout), .ff_ren(ff_ren),
        .addr_rst(addr_rst), .addr_inc(addr_inc), .gen_addr(gen_addr),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // FIFO model: read data valid the cycle after a pop
    logic [31:0] fifo_q[$];
    always @(posedge clk) begin
        if (ff_ren && fifo_q.size() > 0) ff_dout <= fifo_q.pop_front();
    end

    // Address generator model: entry offset within the current pass save-point
    int cfg_e = 1;
    int cfg_c = 1;
    int gen_cnt = 0;
    always @(posedge clk) begin
        if (rst || addr_rst) gen_cnt <= 0;
        else if (addr_inc)   gen_cnt <= gen_cnt + 1;
    end
    always_comb begin
        if (cfg_e * cfg_c == 0) gen_addr = 32'd0;
        else gen_addr = 32'((gen_cnt / (cfg_e * cfg_c)) * cfg_e + (gen_cnt % cfg_e));
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ff_ren"},    32'(ff_ren),   32'd0);
        chk({tag, "_addr_inc"},  32'(addr_inc), 32'd0);
        chk({tag, "_addr_rst"},  32'(addr_rst), 32'd0);
        chk({tag, "_bram_en"},   32'(bram_en),  32'd0);
        chk({tag, "_bram_we"},   32'(bram_we),  32'd0);
        chk({tag, "_bram_addr"}, bram_addr,     32'd0);
        chk({tag, "_bram_din"},  bram_din,      32'd0);
        chk({tag, "_busy"},      32'(busy),     32'd0);
        chk({tag, "_done"},      32'(done),     32'd0);
    endtask

    // bubble: 0 never empty, 1 empty on alternate cycles, 2 random empties
    task automatic run_cfg(input int e, input int c, input int p, input int bubble,
                           input bit restart_mid, input int rst_after);
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] w;
        int n_total, wi, pops, ndone, n;
        bit prev_we, finished;
        n_total = e * c * p;
        fifo_q.delete();
        for (int pp = 0; pp < p; pp++)
            for (int cc = 0; cc < c; cc++)
                for (int ee = 0; ee < e; ee++) begin
                    w = $urandom;
                    exp_addr.push_back(32'(pp * e + ee));
                    exp_data.push_back(w);
                    fifo_q.push_back(w);
                end
        cfg_e = e;
        cfg_c = c;
        no_entry   = 16'(e);
        no_channel = 11'(c);
        no_pass    = 8'(p);
        @(negedge clk);
        ff_empty = (fifo_q.size() == 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        no_entry   = 16'($urandom);
        no_channel = 11'($urandom);
        no_pass    = 8'($urandom);
        chk("clear_addr_rst", 32'(addr_rst), 32'd1);
        chk("clear_busy", 32'(busy), 32'd1);
        wi = 0; pops = 0; ndone = 0; prev_we = 1'b0; finished = 1'b0;
        for (n = 2; n < 400 && !finished; n++) begin
            @(negedge clk);
            chk("addr_rst_one_cycle", 32'(addr_rst), 32'd0);
            if (bram_we) begin
                chk("en_eq_we", 32'(bram_en), 32'd1);
                if (wi < n_total) begin
                    chk("bram_addr", bram_addr, exp_addr[wi]);
                    chk("bram_din", bram_din, exp_data[wi]);
                end else begin
                    chk("extra_write", 32'(wi), 32'(n_total));
                end
                wi++;
            end
            if (done) begin
                ndone++;
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("writes_at_done", 32'(wi), 32'(n_total));
                if (n_total == 0) chk("zero_done_latency", 32'(n), 32'd2);
                else              chk("done_after_last_we", 32'(prev_we), 32'd1);
                finished = 1'b1;
            end
            prev_we = bram_we;
            start = (restart_mid && n == 6);
            if (rst_after > 0 && wi == rst_after) begin
                rst = 1'b1;
                @(negedge clk);
                chk_reset_outputs("midrst");
                rst = 1'b0;
                start = 1'b0;
                return;
            end
            ff_empty = (fifo_q.size() == 0) || (bubble == 1 && (n % 2) == 1) ||
                       (bubble == 2 && $urandom_range(0, 2) == 0);
            #1;
            chk("addr_inc_eq_ff_ren", 32'(addr_inc), 32'(ff_ren));
            if (ff_ren) pops++;
        end
        start = 1'b0;
        chk("finished_in_time", 32'(finished), 32'd1);
        chk("pop_count", 32'(pops), 32'(n_total));
        chk("write_count", 32'(wi), 32'(n_total));
        chk("done_count", 32'(ndone), 32'd1);
        @(negedge clk);
        chk("idle_done_low", 32'(done), 32'd0);
        chk("idle_busy_low", 32'(busy), 32'd0);
        chk("idle_we_low", 32'(bram_we), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ff_empty = 1'b1;
        no_entry = '0;
        no_channel = '0;
        no_pass = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        run_cfg(4, 2, 2, 0, 1'b0, 0);   // streaming
        run_cfg(4, 2, 2, 1, 1'b0, 0);   // alternate bubbles
        run_cfg(4, 0, 2, 0, 1'b0, 0);   // zero channel count
        run_cfg(4, 2, 2, 0, 1'b1, 0);   // start while busy
        run_cfg(4, 2, 2, 0, 1'b0, 0);   // rerun from address 0
        run_cfg(4, 2, 2, 0, 1'b0, 5);   // reset after 5 writes
        run_cfg(4, 2, 2, 0, 1'b0, 0);
        run_cfg(1, 1, 1, 0, 1'b0, 0);   // minimal config
        run_cfg(0, 3, 1, 0, 1'b0, 0);
        run_cfg(2, 2, 0, 0, 1'b0, 0);
        for (int k = 0; k < 6; k++)
            run_cfg(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 3)), 2, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
